add_sub_8bit: RTL and testbench
===============================

// Module: add_sub_8bit
// PURPOSE
//   Registered BITS-wide unsigned/two's-complement adder-subtractor with condition codes.
//   Computes x+y (sub=0) or x-y (sub=1) and produces carry, negative, zero and overflow flags.
//   Sits in the datapath ALU slice; one result per accepted input, one-cycle latency.
// PARAMETERS
//   BITS  8  operand/result width (>=2)
// PORTS
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous reset, active-high
//   in_valid   in   1     x/y/sub valid this cycle
//   x          in   BITS  operand A
//   y          in   BITS  operand B
//   sub        in   1     0: add, 1: subtract
//   cin        in   1     carry/borrow in (only with ADD_SUB_CARRY_IN_EN)
//   out_valid  out  1     result/flags valid
//   result     out  BITS  sum/difference, low BITS bits
//   ccc        out  1     carry flag
//   ccn        out  1     negative / borrow flag
//   ccz        out  1     zero flag
//   ccv        out  1     signed overflow flag
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (rst).
//   - rst=1 at posedge: out_valid, result, ccc, ccn, ccz, ccv all <= 0. Reset overrides in_valid.
//   - Core: yb = y ^ {BITS{sub}}; {cout, s} = x + yb + sub (ripple of full adders).
//   - R9 = {sub ? ~cout : cout, s}, i.e. the exact BITS+1-bit value of x+y or x-y.
//   - result = s (wraps modulo 2^BITS).
//   - ccc = cout. Add: unsigned carry out. Sub: 1 iff x>=y (no borrow), 0 iff x<y.
//   - ccn = sub & ~cout, i.e. 1 iff subtracting and x<y unsigned. Always 0 for add.
//   - ccz = (R9 == 0). Sub: 1 iff x==y. Add: 1 only for x=y=0. 0x80+0x80 gives result 0 but ccz=0.
//   - ccv = (x[BITS-1] == yb[BITS-1]) & (s[BITS-1] != x[BITS-1]).
//     This is two's-complement overflow for both add and sub.
//   - Latency: 1 cycle. When in_valid=1 at posedge, out_valid<=1 and all outputs update.
//   - When in_valid=0, out_valid<=0 and result/flags hold their previous values.
//   - No backpressure; a new input can be accepted every cycle.
// CONFIGURATION
//   ADD_SUB_CARRY_IN_EN defined:
//     - cin port exists. Add computes x+y+cin. Sub computes x-y-cin (cin is a borrow).
//     - Core carry-in = sub ? ~cin : cin.
//     - R9 = exact x+y+cin or x-y-cin; all flags use the same formulas on it.
//   Not defined: no cin port; behaviour identical to cin=0.
// STRUCTURE
//   - Package add_sub_pkg:
//     - ADD_SUB_BITS_DEFAULT = 8.
//     - typedef struct packed {logic c, n, z, v;} cc_flags_t.
//     - function cc_flags_t calc_flags(...) shared by RTL and bench model.
//   - Sub-module add_sub_fa: 1-bit full adder (a, b, ci -> s, co).
//     Instantiated BITS times in a generate ripple chain; the output register lives in the top module.
// TESTING
//   1. rst=1 two cycles, in_valid=1 -> out_valid=0, result=0, all flags 0.
//   2. add x=0x80 y=0x80 -> result=0x00, ccc=1, ccz=0, ccn=0, ccv=1.
//   3. sub x=0x05 y=0x05 -> result=0x00, ccz=1, ccc=1, ccn=0, ccv=0.
//   4. sub x=0x03 y=0x05 -> result=0xFE, ccc=0, ccn=1, ccz=0, ccv=0.
//   5. add x=0x7F y=0x01 -> result=0x80, ccv=1, ccc=0; sub x=0x80 y=0x01 -> result=0x7F, ccv=1, ccc=1.
//   6. 250 random x/y/sub with in_valid toggling, compared to the calc_flags model one cycle later.
//      Outputs must hold while in_valid=0; rst=1 mid-stream clears all outputs next edge.

Source files
------------

// File: rtl/add_sub_8bit_pkg.sv
`default_nettype none
// ============================================================================
// Package   : add_sub_pkg
// Purpose   : Shared width default, condition-code struct and the flag
//             derivation used by the add_sub_8bit datapath slice.
// Config    : ADD_SUB_CARRY_IN_EN (optional carry/borrow in; see top module)
// Revision  : 1.0 - initial release
// ============================================================================
package add_sub_pkg;

  localparam int ADD_SUB_BITS_DEFAULT = 8;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
    logic v;
  } cc_flags_t;

  // Flags from the adder core. The (BITS+1)-bit exact value R9 is
  // {sub ? ~cout : cout, s}, so zero needs both the low bits and that top
  // bit to be clear.
  function automatic cc_flags_t calc_flags(
    input logic sub,
    input logic cout,
    input logic s_zero,
    input logic x_msb,
    input logic yb_msb,
    input logic s_msb
  );
    cc_flags_t f;
    logic      r_top;
    r_top = sub ? ~cout : cout;
    f.c   = cout;
    f.n   = sub & ~cout;
    f.z   = s_zero & ~r_top;
    f.v   = (x_msb == yb_msb) & (s_msb != x_msb);
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub_8bit_if.sv
`default_nettype none
// ============================================================================
// Interface : add_sub_8bit_if
// Purpose   : Operand/result bundle for add_sub_8bit.
//             master : drives in_valid, x, y, sub (and cin); reads results
//             slave  : the adder-subtractor itself
// Config    : ADD_SUB_CARRY_IN_EN adds the cin signal
// Revision  : 1.0 - initial release
// ============================================================================
interface add_sub_8bit_if
  import add_sub_pkg::*;
#(
  parameter int BITS = ADD_SUB_BITS_DEFAULT
);
  logic            in_valid;
  logic [BITS-1:0] x;
  logic [BITS-1:0] y;
  logic            sub;
`ifdef ADD_SUB_CARRY_IN_EN
  logic            cin;
`endif
  logic            out_valid;
  logic [BITS-1:0] result;
  logic            ccc;
  logic            ccn;
  logic            ccz;
  logic            ccv;

  modport master (
    output in_valid, x, y, sub,
`ifdef ADD_SUB_CARRY_IN_EN
    output cin,
`endif
    input  out_valid, result, ccc, ccn, ccz, ccv
  );

  modport slave (
    input  in_valid, x, y, sub,
`ifdef ADD_SUB_CARRY_IN_EN
    input  cin,
`endif
    output out_valid, result, ccc, ccn, ccz, ccv
  );

endinterface
`default_nettype wire

// File: rtl/add_sub_8bit_fa.sv
`default_nettype none
// ============================================================================
// Module    : add_sub_fa
// Purpose   : One-bit full adder, the cell of the ripple chain.
// Ports     : a, b, ci (in) -> s, co (out)
// Revision  : 1.0 - initial release
// ============================================================================
module add_sub_fa (
  input  wire logic a,
  input  wire logic b,
  input  wire logic ci,
  output logic      s,
  output logic      co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/add_sub_8bit.sv
`default_nettype none
// ============================================================================
// Module    : add_sub_8bit
// Purpose   : Registered BITS-wide adder-subtractor with condition codes,
//             one-cycle latency, one result per accepted input.
// Ports     : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - add_sub_8bit_if.slave (in_valid, x, y, sub, [cin],
//                    out_valid, result, ccc, ccn, ccz, ccv)
// Config    : ADD_SUB_CARRY_IN_EN - adds cin (carry for add, borrow for sub)
// Revision  : 1.0 - initial release
// ============================================================================
module add_sub_8bit
  import add_sub_pkg::*;
#(
  parameter int BITS = ADD_SUB_BITS_DEFAULT
) (
  input  wire logic     clk,
  input  wire logic     rst,
  add_sub_8bit_if.slave bus
);

  logic [BITS-1:0] w_yb;
  logic [BITS-1:0] w_s;
  logic [BITS:0]   w_c;
  cc_flags_t       w_flags;

  logic            r_valid;
  logic [BITS-1:0] r_result;
  cc_flags_t       r_flags;

  // Subtraction is x + ~y + 1; an incoming borrow removes that +1.
`ifdef ADD_SUB_CARRY_IN_EN
  assign w_c[0] = bus.sub ? ~bus.cin : bus.cin;
`else
  assign w_c[0] = bus.sub;
`endif

  assign w_yb = bus.y ^ {BITS{bus.sub}};

  generate
    for (genvar i = 0; i < BITS; i++) begin : g_ripple
      add_sub_fa u_fa (
        .a  (bus.x[i]),
        .b  (w_yb[i]),
        .ci (w_c[i]),
        .s  (w_s[i]),
        .co (w_c[i+1])
      );
    end
  endgenerate

  assign w_flags = calc_flags(bus.sub, w_c[BITS], (w_s == '0),
                              bus.x[BITS-1], w_yb[BITS-1], w_s[BITS-1]);

  // Result and flags only load on accepted inputs; otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_s;
        r_flags  <= w_flags;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.result    = r_result;
  assign bus.ccc       = r_flags.c;
  assign bus.ccn       = r_flags.n;
  assign bus.ccz       = r_flags.z;
  assign bus.ccv       = r_flags.v;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_8bit.sv
`default_nettype none
// ============================================================================
// Module    : tb_add_sub_8bit
// Purpose   : Self-checking bench for add_sub_8bit (BITS=8). Directed
//             vectors with literal expectations plus a random stream checked
//             every cycle against an integer-arithmetic model.
// Config    : ADD_SUB_CARRY_IN_EN drives and models cin when defined
// Revision  : 1.0 - initial release
// ============================================================================
module tb_add_sub_8bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_cin = 1'b0;
  logic cin_eff;

  always #5 clk = ~clk;

  add_sub_8bit_if #(.BITS(8)) bus ();

  add_sub_8bit #(.BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ADD_SUB_CARRY_IN_EN
  assign bus.cin = tb_cin;
  assign cin_eff = tb_cin;
`else
  assign cin_eff = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // {c, n, z, v, result} from exact integer arithmetic.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic s, input logic ci);
    int ex;
    int se;
    int sa;
    int sb;
    int ic;
    logic [7:0] r;
    logic c, n, z, v;
    ic = int'(ci);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ex = s ? int'(a) - int'(b) - ic : int'(a) + int'(b) + ic;
    se = s ? sa - sb - ic : sa + sb + ic;
    r  = ex[7:0];
    c  = s ? (ex >= 0) : (ex > 255);
    n  = s && (ex < 0);
    z  = (ex == 0);
    v  = (se > 127) || (se < -128);
    return {c, n, z, v, r};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {valid,c,n,z,v,result}=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] dut_word();
    return {bus.out_valid, bus.ccc, bus.ccn, bus.ccz, bus.ccv, bus.result};
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic ci);
    bus.in_valid = v;
    bus.x        = a;
    bus.y        = b;
    bus.sub      = s;
    tb_cin       = ci;
  endtask

  // Waits one edge, then pins both the DUT and the model to a literal.
  task automatic lit(input string name, input logic [11:0] exp);
    @(negedge clk);
    check({name, "_dut"}, dut_word(), {1'b1, exp});
    check({name, "_model"}, {1'b1, model(bus.x, bus.y, bus.sub, cin_eff)}, {1'b1, exp});
  endtask

  // Cycle-by-cycle reference for valid/hold/reset behaviour.
  logic        m_started = 1'b0;
  logic        m_valid   = 1'b0;
  logic [11:0] m_out     = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1'b1;
      m_valid   = 1'b0;
      m_out     = '0;
    end else if (bus.in_valid) begin
      m_valid = 1'b1;
      m_out   = model(bus.x, bus.y, bus.sub, cin_eff);
    end else begin
      m_valid = 1'b0;
    end
    #1;
    if (m_started) check("cycle", dut_word(), {m_valid, m_out});
  end

  initial begin
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset", dut_word(), 13'h0000);
    rst = 1'b0;

    drive(1'b1, 8'h80, 8'h80, 1'b0, 1'b0); lit("add_80_80", {4'b1001, 8'h00});
    drive(1'b1, 8'h05, 8'h05, 1'b1, 1'b0); lit("sub_05_05", {4'b1010, 8'h00});
    drive(1'b1, 8'h03, 8'h05, 1'b1, 1'b0); lit("sub_03_05", {4'b0100, 8'hFE});
    drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0); lit("add_7F_01", {4'b0001, 8'h80});
    drive(1'b1, 8'h80, 8'h01, 1'b1, 1'b0); lit("sub_80_01", {4'b1001, 8'h7F});
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0); lit("add_00_00", {4'b0010, 8'h00});
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0); lit("add_FF_01", {4'b1000, 8'h00});

    // Idle cycle: out_valid drops, result/flags of the last op hold.
    drive(1'b0, 8'h12, 8'h34, 1'b1, 1'b0);
    @(negedge clk);
    check("hold", dut_word(), {1'b0, 4'b1000, 8'h00});

    for (int i = 0; i < 250; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst = (i == 150);
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
